spi_ram_ctrl: RTL
=================

# spi_ram_ctrl

SPI slave controller that sequences the 256×8 dual-port RAM. It deserialises MOSI frames into 10-bit RAM command words (`rx_data` / `rx_valid`) and tracks the write / read-address / read-data phase. It captures the RAM's `tx_data` / `tx_valid` response and serialises it onto MISO. It sits between the chip-level SPI pins and the RAM command port.

## Interface
- `TX_TIMEOUT`, default 15: maximum cycles to wait for `tx_valid` after issuing a read-data word.
- `clk`  in  1  system clock; doubles as SCK, all sampling on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SS_n`  in  1  slave select, active-low; frames a transaction.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; registered.
- `rx_data`  out  10  command word to RAM: [9:8] opcode, [7:0] address/data.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  in  8  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid strobe from RAM.

## Operation
- **Opcodes** (`rx_data[9:8]`):
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- **`rd_addr_seen` flag:**
  - Set when a READ_ADD frame completes.
  - Cleared when a READ_DATA frame completes.
  - Cleared by reset.
- **IDLE:**
  - `SS_n`=0 → CHK_CMD.
  - Bit counter and shift register cleared.
- **CHK_CMD:**
  - Samples MOSI as bit 9 into the shift register.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_seen`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_seen`=1 → READ_DATA.
- **WRITE / READ_ADD / READ_DATA:**
  - Shift in the remaining 9 bits, MSB first.
  - On the edge capturing bit 0: load `rx_data`, set `rx_valid`.
  - From WRITE and READ_ADD → DONE.
  - From READ_DATA → TX_WAIT.
- **The opcode is forwarded verbatim.** The controller does not correct `rx_data[8]`. A READ_ADD frame carrying opcode 11 is passed through as-is; the flag still sets.
- **TX_WAIT:**
  - On `tx_valid`=1: latch `tx_data`, → TX_SHIFT.
  - After `TX_TIMEOUT` cycles without `tx_valid` → DONE, MISO stays 0.
- **TX_SHIFT:**
  - Drives the latched byte on MISO, MSB first, one bit per cycle, 8 cycles.
  - Then → DONE.
- **DONE:**
  - MISO=0.
  - Stays until `SS_n`=1.
- **`SS_n`=1 in any state** → IDLE on the next edge:
  - A partial frame is discarded; `rx_valid` is not asserted and `rx_data` is unchanged.
  - `rd_addr_seen` is not modified by an aborted frame.
- **`tx_valid` outside TX_WAIT** is ignored.

## Timing
- **Reset values:**
  - state=IDLE
  - `MISO`=0
  - `rx_data`=10'h000
  - `rx_valid`=0
  - `rd_addr_seen`=0
  - bit counter=0
- **Write-class frame:**
  - Edge E0: `SS_n` low seen, → CHK_CMD.
  - Edges E1–E10: capture bits 9..0.
  - `rx_valid` is high in the cycle after E10, for exactly 1 cycle.
- **`rx_data`** holds its value until the next completed frame.
- **Read data:**
  - RAM returns `tx_valid` 1 cycle after `rx_valid` (`tx_valid` sampled at E12).
  - MISO bit 7 is valid after E13; bit 0 after E20.
  - The master must hold `SS_n` low through E20.
- **Timeout counter** starts on entry to TX_WAIT and counts 1..`TX_TIMEOUT`.
- **Back-to-back frames** require `SS_n` high for ≥1 edge between them.
- **Reset mid-frame:** outputs go to reset values immediately (asynchronously). `rd_addr_seen` is lost.

## Test plan
- **Write pair.** Frame 10'b00_0001_0000, then 10'b01_1010_0101 →
  - `rx_valid` pulses once per frame.
  - `rx_data` = 0x010, then 0x1A5.
- **Read sequence.** Frame 10'b10_0001_0000 (flag sets), then 10'b11_0000_0000 with the model RAM returning `tx_data`=8'hA5 one cycle later →
  - MISO = 1,0,1,0,0,1,0,1 on edges E13–E20.
  - Flag clears.
- **Flag steering.** Two consecutive read frames starting with MOSI=1 →
  - The first enters READ_ADD; the second enters READ_DATA.
  - A third enters READ_ADD again.
- **Abort.** Raise `SS_n` after 5 bits of a write frame →
  - No `rx_valid`; `rx_data` unchanged.
  - Next full frame is decoded correctly.
- **Timeout.** Read-data frame with `tx_valid` withheld → after 15 cycles in TX_WAIT:
  - Controller is in DONE, MISO=0.
  - Returns to IDLE when `SS_n`=1.
- **Async reset.** Assert `rst_n` mid-TX_SHIFT →
  - MISO=0, `rx_valid`=0, flag=0 immediately.
  - Next frame starting with MOSI=1 enters READ_ADD.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
`timescale 1ns/1ps
// spi_ram_ctrl
// SPI slave front end for the 256x8 dual-port RAM. MOSI frames of 10 bits
// (MSB first) become RAM command words on rx_data/rx_valid. A read-data
// command is answered by the RAM on tx_data/tx_valid, and that byte is
// shifted back out on MISO, MSB first. clk doubles as SCK.
//
// Ports
//   clk       system clock / SCK, rising-edge sampling
//   rst_n     asynchronous active-low reset
//   SS_n      slave select, active-low, frames a transaction
//   MOSI      serial data in, MSB first
//   MISO      serial data out, MSB first, registered
//   rx_data   command word to RAM: [9:8] opcode, [7:0] address/data
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read data from RAM
//   tx_valid  strobe qualifying tx_data
module spi_ram_ctrl #(
  parameter int TX_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  // Timeout counter holds 0..TX_TIMEOUT-1 (cycles already spent waiting).
  localparam int TW = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_TX_SHIFT  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t          state_r;
  logic [8:0]      shift_r;         // bits 9..1 of the frame; bit 0 joins on the last edge
  logic [3:0]      bit_cnt_r;       // frame bits captured / MISO bits sent
  logic [TW-1:0]   tcnt_r;
  logic [7:0]      tx_byte_r;       // latched RAM byte, shifted left as it goes out
  logic            rd_addr_seen_r;  // a read address was sent, next read frame is read-data
  logic            miso_r;
  logic [9:0]      rx_data_r;
  logic            rx_valid_r;

  assign MISO     = miso_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;

  // Frame sequencer: deserialise MOSI, issue the command word, serialise read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      shift_r        <= 9'd0;
      bit_cnt_r      <= 4'd0;
      tcnt_r         <= '0;
      tx_byte_r      <= 8'd0;
      rd_addr_seen_r <= 1'b0;
      miso_r         <= 1'b0;
      rx_data_r      <= 10'h000;
      rx_valid_r     <= 1'b0;
    end else begin
      // Strobe and MISO default low; only TX_SHIFT drives data bits.
      rx_valid_r <= 1'b0;
      miso_r     <= 1'b0;
      if (SS_n) begin
        // Deselect aborts whatever is in flight; rx_data and the flag are untouched.
        state_r   <= ST_IDLE;
        shift_r   <= 9'd0;
        bit_cnt_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            shift_r   <= 9'd0;
            bit_cnt_r <= 4'd0;
            state_r   <= ST_CHK_CMD;
          end
          ST_CHK_CMD: begin
            // First frame bit decides the class; a read frame alternates
            // between address and data using the flag, not the opcode.
            shift_r   <= {8'd0, MOSI};
            bit_cnt_r <= 4'd1;
            if (!MOSI) begin
              state_r <= ST_WRITE;
            end else if (rd_addr_seen_r) begin
              state_r <= ST_READ_DATA;
            end else begin
              state_r <= ST_READ_ADD;
            end
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            shift_r <= {shift_r[7:0], MOSI};
            if (bit_cnt_r == 4'd9) begin
              // Opcode goes out exactly as received.
              rx_data_r  <= {shift_r, MOSI};
              rx_valid_r <= 1'b1;
              bit_cnt_r  <= 4'd0;
              if (state_r == ST_READ_DATA) begin
                rd_addr_seen_r <= 1'b0;
                tcnt_r         <= '0;
                state_r        <= ST_TX_WAIT;
              end else if (state_r == ST_READ_ADD) begin
                rd_addr_seen_r <= 1'b1;
                state_r        <= ST_DONE;
              end else begin
                state_r <= ST_DONE;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          ST_TX_WAIT: begin
            // tx_valid wins over the timeout on the last allowed cycle.
            if (tx_valid) begin
              tx_byte_r <= tx_data;
              bit_cnt_r <= 4'd0;
              state_r   <= ST_TX_SHIFT;
            end else if (tcnt_r == TW'(TX_TIMEOUT - 1)) begin
              state_r <= ST_DONE;
            end else begin
              tcnt_r <= tcnt_r + TW'(1);
            end
          end
          ST_TX_SHIFT: begin
            miso_r    <= tx_byte_r[7];
            tx_byte_r <= {tx_byte_r[6:0], 1'b0};
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_r <= 4'd0;
              state_r   <= ST_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
